reaction_controller: RTL and testbench



---
 rtl/reaction_controller_if.sv | 40 ++++
 rtl/reaction_controller.sv | 168 ++++++++++++++++
 tb/tb_reaction_controller.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_controller_if.sv
// reaction_controller_if
//   Bundles the reaction-timer pins so the controller and its environment
//   connect through one port.
//   master : environment side (drives tick/start/stop/count, observes outputs)
//   slave  : controller side
//   Signals:
//     tick         1  one-clock-wide 1 kHz timebase pulse
//     start        1  synchronized start button level
//     stop         1  synchronized reaction button level
//     count        13 current value of the downstream up counter
//     count_enable 1  increment enable to the counter
//     count_reset  1  active-high clear to the counter
//     led          1  "react now" lamp
//     result       13 latched reaction time in ms
//     valid        1  result holds a completed round
//     false_start  1  stop pressed before the lamp lit
//     best         13 smallest valid result since reset
interface reaction_controller_if;
  logic        tick;
  logic        start;
  logic        stop;
  logic [12:0] count;
  logic        count_enable;
  logic        count_reset;
  logic        led;
  logic [12:0] result;
  logic        valid;
  logic        false_start;
  logic [12:0] best;

  modport master (
    output tick, start, stop, count,
    input  count_enable, count_reset, led, result, valid, false_start, best
  );

  modport slave (
    input  tick, start, stop, count,
    output count_enable, count_reset, led, result, valid, false_start, best
  );
endinterface

// File: rtl/reaction_controller.sv
// reaction_controller
//   Reaction-time game sequencer. A start press arms a pseudo-random wait of
//   MIN_DELAY plus 0..2^RAND_BITS-1 ms; when it expires the lamp lights and an
//   external 13-bit counter measures the reaction in ms until stop is
//   pressed. Pressing stop during the wait is a false start. The fastest
//   completed round since reset is tracked in best.
//   Parameters:
//     MIN_DELAY  minimum armed wait in ticks (ms)
//     RAND_BITS  width of the random extra wait
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    reaction_controller_if.slave (see interface header)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | after reset, counter cleared, waiting for first start press
//   S_WAIT | armed, counting the random delay down on each tick
//   S_GO   | lamp lit, external counter measuring the reaction
//   S_DONE | round complete, result valid, counter frozen
//   S_FOUL | stop pressed during the wait, counter cleared
module reaction_controller #(
  parameter int MIN_DELAY = 1000,
  parameter int RAND_BITS = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reaction_controller_if.slave  bus
);

  localparam int          DELAY_W   = $clog2(MIN_DELAY + (1 << RAND_BITS) + 1);
  localparam logic [12:0] COUNT_MAX = 13'h1FFF;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE,
    S_FOUL
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 start_q;
  logic                 stop_q;
  logic                 start_rise;
  logic                 stop_rise;
  logic [15:0]          lfsr;
  logic [DELAY_W-1:0]   delay;
  logic [DELAY_W-1:0]   delay_load;
  logic [12:0]          result_r;
  logic [12:0]          best_r;
  logic                 load_delay;
  logic                 dec_delay;
  logic                 capture;
  logic                 count_enable;

  assign start_rise = bus.start & ~start_q;
  assign stop_rise  = bus.stop  & ~stop_q;
  assign delay_load = DELAY_W'(MIN_DELAY) + DELAY_W'(lfsr[RAND_BITS-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= bus.start;
      stop_q  <= bus.stop;
    end
  end

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1; maximal length, so a non-zero
  // seed never reaches the all-zero lock-up state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    load_delay   = 1'b0;
    dec_delay    = 1'b0;
    capture      = 1'b0;
    count_enable = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_FOUL: begin
        if (start_rise) begin
          state_next = S_WAIT;
          load_delay = 1'b1;
        end
      end
      S_WAIT: begin
        // A stop edge wins over a tick that would end the wait.
        if (stop_rise) begin
          state_next = S_FOUL;
        end else if (bus.tick) begin
          if (delay <= DELAY_W'(1)) begin
            state_next = S_GO;
          end else begin
            dec_delay = 1'b1;
          end
        end
      end
      S_GO: begin
        // Capture uses the count before any increment this cycle, and the
        // counter is not advanced past its maximum.
        if (stop_rise) begin
          state_next = S_DONE;
          capture    = 1'b1;
        end else if (bus.tick) begin
          if (bus.count == COUNT_MAX) begin
            state_next = S_DONE;
            capture    = 1'b1;
          end else begin
            count_enable = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay <= '0;
    end else if (load_delay) begin
      delay <= delay_load;
    end else if (dec_delay) begin
      delay <= delay - DELAY_W'(1);
    end
  end

  // best is updated from the same count value that goes into result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= '0;
      best_r   <= COUNT_MAX;
    end else if (capture) begin
      result_r <= bus.count;
      if (bus.count < best_r) begin
        best_r <= bus.count;
      end
    end
  end

  assign bus.count_enable = count_enable;
  assign bus.count_reset  = (state == S_IDLE) || (state == S_WAIT) || (state == S_FOUL);
  assign bus.led          = (state == S_GO);
  assign bus.valid        = (state == S_DONE);
  assign bus.false_start  = (state == S_FOUL);
  assign bus.result       = result_r;
  assign bus.best         = best_r;

endmodule

// File: tb/tb_reaction_controller.sv
// tb_reaction_controller
//   Self-checking bench for reaction_controller with MIN_DELAY=4, RAND_BITS=1.
//   A bench-side 13-bit counter plays the downstream counter. A game-level
//   model (phase, remaining wait, elapsed ms) predicts every output each cycle.
module tb_reaction_controller;
  localparam int MIN_DELAY = 4;
  localparam int RAND_BITS = 1;
  localparam int CLK_HALF  = 5;
  localparam int MAX_MS    = 8191;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_LIT   = 2;
  localparam int P_DONE  = 3;
  localparam int P_FOUL  = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] cnt   = '0;

  reaction_controller_if bus ();

  reaction_controller #(
    .MIN_DELAY (MIN_DELAY),
    .RAND_BITS (RAND_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #CLK_HALF clk = ~clk;

  always @(posedge clk) begin
    if (bus.count_reset)       cnt <= '0;
    else if (bus.count_enable) cnt <= cnt + 13'd1;
  end
  assign bus.count = cnt;

  int errors = 0;
  int checks = 0;

  // game-level reference
  int          m_phase;
  int          m_remain;
  int          m_elapsed;
  int          m_result;
  int          m_best;
  logic [15:0] m_lfsr;
  logic        m_start_prev;
  logic        m_stop_prev;
  logic        last_ce;

  typedef struct {
    logic t, s, p;
    logic ce, led, valid, fs, cr;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_reset();
    m_phase      = P_IDLE;
    m_remain     = 0;
    m_elapsed    = 0;
    m_result     = 0;
    m_best       = MAX_MS;
    m_lfsr       = 16'hACE1;
    m_start_prev = 1'b0;
    m_stop_prev  = 1'b0;
  endtask

  task automatic model_step(input logic t, input logic sr, input logic pr, input logic s, input logic p);
    case (m_phase)
      P_IDLE, P_DONE, P_FOUL: begin
        if (sr) begin
          m_phase  = P_ARMED;
          m_remain = MIN_DELAY + (int'(m_lfsr) % (1 << RAND_BITS));
        end
      end
      P_ARMED: begin
        if (pr) m_phase = P_FOUL;
        else if (t) begin
          if (m_remain <= 1) begin
            m_phase   = P_LIT;
            m_elapsed = 0;
          end else begin
            m_remain--;
          end
        end
      end
      P_LIT: begin
        if (pr || (t && m_elapsed == MAX_MS)) begin
          m_phase  = P_DONE;
          m_result = m_elapsed;
          if (m_elapsed < m_best) m_best = m_elapsed;
        end else if (t) begin
          m_elapsed++;
        end
      end
      default: ;
    endcase
    m_lfsr       = lfsr_step(m_lfsr);
    m_start_prev = s;
    m_stop_prev  = p;
  endtask

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic cyc(input logic t, input logic s, input logic p);
    logic sr, pr, exp_ce;
    logic [30:0] act, exp;
    bus.tick  = t;
    bus.start = s;
    bus.stop  = p;
    sr     = s & ~m_start_prev;
    pr     = p & ~m_stop_prev;
    exp_ce = (m_phase == P_LIT) && t && !pr && (m_elapsed != MAX_MS);
    #(CLK_HALF - 1);
    last_ce = bus.count_enable;
    @(posedge clk);
    #1;
    model_step(t, sr, pr, s, p);
    act = {last_ce, bus.led, bus.valid, bus.false_start, bus.count_reset, bus.result, bus.best};
    exp = {exp_ce, m_phase == P_LIT, m_phase == P_DONE, m_phase == P_FOUL,
           (m_phase == P_IDLE) || (m_phase == P_ARMED) || (m_phase == P_FOUL),
           13'(m_result), 13'(m_best)};
    chk("model", 64'(act), 64'(exp));
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async {led,valid,fs,cr,ce,result,best}",
        64'({bus.led, bus.valid, bus.false_start, bus.count_reset, bus.count_enable, bus.result, bus.best}),
        64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'd0, 13'd8191}));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Press start on a cycle where the random bit is 0, so the wait is exactly
  // MIN_DELAY ticks; then deliver those ticks and confirm the lamp timing.
  task automatic press_and_light();
    int guard;
    cyc(1'b0, 1'b0, 1'b0);
    guard = 0;
    while (m_lfsr[0] != 1'b0 && guard < 40) begin
      cyc(1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("lfsr_even_found", 64'(guard < 40), 64'd1);
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= MIN_DELAY; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i == MIN_DELAY - 1) chk("led_before_last_tick", 64'(bus.led), 64'd0);
      if (i == MIN_DELAY)     chk("led_after_last_tick", 64'(bus.led), 64'd1);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic play_round(input int react_ms, input int exp_best);
    press_and_light();
    run_ticks(react_ms);
    chk("count_before_stop", 64'(cnt), 64'(react_ms));
    cyc(1'b0, 1'b0, 1'b1);
    chk("round_result", 64'(bus.result), 64'(react_ms));
    chk("round_valid", 64'(bus.valid), 64'd1);
    chk("round_best", 64'(bus.best), 64'(exp_best));
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic rt, rs, rp, prev_t;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    model_reset();

    //        t     s     p     ce    led   valid fs    cr
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // stop in idle ignored
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // armed
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // tick 1
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // start in wait ignored
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // tick 2
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // false start
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // stop in foul ignored
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // re-armed from foul
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // foul with no ticks
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // re-armed
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // foul

    @(negedge clk);
    apply_reset();

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].t, vecs[i].s, vecs[i].p);
      chk($sformatf("vec%0d {ce,led,valid,fs,cr,result,best}", i),
          64'({last_ce, bus.led, bus.valid, bus.false_start, bus.count_reset, bus.result, bus.best}),
          64'({vecs[i].ce, vecs[i].led, vecs[i].valid, vecs[i].fs, vecs[i].cr, 13'd0, 13'd8191}));
    end
    cyc(1'b0, 1'b0, 1'b0);

    play_round(250, 250);
    play_round(300, 250);
    play_round(120, 120);

    // timeout at full scale
    press_and_light();
    run_ticks(MAX_MS);
    chk("timeout_count_full", 64'(cnt), 64'd8191);
    chk("timeout_led_still_on", 64'(bus.led), 64'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("timeout_ce", 64'(last_ce), 64'd0);
    chk("timeout_result", 64'(bus.result), 64'd8191);
    chk("timeout_valid", 64'(bus.valid), 64'd1);
    chk("timeout_best", 64'(bus.best), 64'd120);
    cyc(1'b0, 1'b0, 1'b0);
    chk("timeout_no_wrap", 64'(cnt), 64'd8191);

    // tick and stop edge in the same cycle
    press_and_light();
    run_ticks(77);
    cyc(1'b1, 1'b0, 1'b1);
    chk("tick_stop_ce", 64'(last_ce), 64'd0);
    chk("tick_stop_result", 64'(bus.result), 64'd77);
    chk("tick_stop_best", 64'(bus.best), 64'd77);
    cyc(1'b0, 1'b0, 1'b0);

    // randomized play against the model
    rs = 1'b0;
    rp = 1'b0;
    prev_t = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rt = !prev_t && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0)  rs = ~rs;
      if ($urandom_range(0, 14) == 0) rp = ~rp;
      cyc(rt, rs, rp);
      prev_t = rt;
    end
    cyc(1'b0, 1'b0, 1'b0);

    // reset in the middle of a lit round
    press_and_light();
    run_ticks(40);
    chk("pre_reset_count", 64'(cnt), 64'd40);
    apply_reset();
    for (int i = 0; i < 6; i++) cyc(i[0], 1'b0, i[1]);
    chk("idle_after_reset {led,valid,fs,cr}",
        64'({bus.led, bus.valid, bus.false_start, bus.count_reset}), 64'({1'b0, 1'b0, 1'b0, 1'b1}));
    cyc(1'b0, 1'b1, 1'b0);
    chk("armed_after_reset {led,cr,result,best}",
        64'({bus.led, bus.count_reset, bus.result, bus.best}), 64'({1'b0, 1'b1, 13'd0, 13'd8191}));
    cyc(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
